// File: rtl/z80_bus_pkg.sv
// rtl/z80_bus_pkg.sv - shared types and constants for the Z80 pin-bus target
// Purpose: FSM state and bus-cycle kind enums, fixed I/O addresses, and the
//          helper that classifies a starting bus cycle.
// Ports:   none (package)
package z80_bus_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_ACCESS,
    S_HOLD
  } bus_state_t;

  typedef enum logic [1:0] {
    K_READ,
    K_WRITE,
    K_INTA
  } bus_kind_t;

  localparam logic [7:0] IO_VECTOR_ADDR = 8'hFF;
  localparam logic [7:0] IO_UNMAPPED    = 8'hFF;

  // INTA outranks everything; rd_n and wr_n both low counts as a write.
  function automatic bus_kind_t decode_kind(input logic iorq_n, input logic wr_n,
                                            input logic m1_n);
    if (!iorq_n && !m1_n) return K_INTA;
    if (!wr_n) return K_WRITE;
    return K_READ;
  endfunction

endpackage

// File: rtl/z80_bus_ram.sv
// rtl/z80_bus_ram.sv - single-port byte RAM with synchronous write and registered read
// Purpose: backing store for the bus target; contents are never reset.
// Ports:   clk   in  clock
//          we    in  write enable
//          addr  in  byte address (log2(MEM_DEPTH) bits)
//          wdata in  write data
//          rdata out registered read data of addr sampled at the last edge
module z80_bus_ram
  import z80_bus_pkg::*;
#(
  parameter int  MEM_DEPTH = 256,
  localparam int AW        = $clog2(MEM_DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [7:0]    wdata,
  output logic [7:0]    rdata
);

  logic [7:0] mem [MEM_DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
    rdata <= mem[addr];
  end

endmodule

// File: rtl/z80_bus_target.sv
// rtl/z80_bus_target.sv - Z80 pin-bus target: RAM, I/O registers, IM2 interrupt source, host loader
// Purpose: answers memory, I/O and INTA cycles of a Z80 core on the same clock.
// Ports:   wb_clk_i, rst_n (async active-low)
//          cpu_addr/cpu_dout/cpu_mreq_n/cpu_iorq_n/cpu_rd_n/cpu_wr_n/cpu_m1_n  CPU bus in
//          cpu_din/cpu_din_oe/cpu_wait_n/cpu_int_n                            CPU bus out
//          irq_req        host interrupt request, rising edge latched
//          ld_we/ld_addr/ld_data/ld_ready  host RAM loader
//          port_q         I/O register contents, port 0 in [7:0]
module z80_bus_target
  import z80_bus_pkg::*;
#(
  parameter int         ADDR_W      = 16,
  parameter int         MEM_DEPTH   = 256,
  parameter int         WAIT_STATES = 0,
  parameter int         N_PORTS     = 4,
  parameter logic [7:0] IRQ_VECTOR  = 8'hFF,
  localparam int        AW          = $clog2(MEM_DEPTH)
) (
  input  logic                 wb_clk_i,
  input  logic                 rst_n,
  input  logic [ADDR_W-1:0]    cpu_addr,
  input  logic [7:0]           cpu_dout,
  input  logic                 cpu_mreq_n,
  input  logic                 cpu_iorq_n,
  input  logic                 cpu_rd_n,
  input  logic                 cpu_wr_n,
  input  logic                 cpu_m1_n,
  output logic [7:0]           cpu_din,
  output logic                 cpu_din_oe,
  output logic                 cpu_wait_n,
  output logic                 cpu_int_n,
  input  logic                 irq_req,
  input  logic                 ld_we,
  input  logic [AW-1:0]        ld_addr,
  input  logic [7:0]           ld_data,
  output logic                 ld_ready,
  output logic [8*N_PORTS-1:0] port_q
);

  localparam logic [3:0] WAIT_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  bus_state_t       state;
  bus_kind_t        cyc_kind;
  logic             cyc_io;
  logic [ADDR_W-1:0] cyc_addr;
  logic [3:0]       wait_cnt;
  logic [7:0]       vector;
  logic             irq_prev;
  logic             irq_rearm;

  logic             bus_active;
  logic             all_released;
  logic             irq_rise;
  logic             inta_access;
  logic             ram_we;
  logic [AW-1:0]    ram_addr;
  logic [7:0]       ram_wdata;
  logic [7:0]       ram_rdata;
  logic [7:0]       io_rdata;
  logic             unused_addr;

  assign bus_active   = ((!cpu_mreq_n || !cpu_iorq_n) && (!cpu_rd_n || !cpu_wr_n)) ||
                        (!cpu_iorq_n && !cpu_m1_n);
  assign all_released = cpu_rd_n & cpu_wr_n & cpu_mreq_n & cpu_iorq_n;
  assign irq_rise     = irq_req & ~irq_prev;
  assign inta_access  = (state == S_ACCESS) && (cyc_kind == K_INTA);
  // Combinational on purpose: acceptance must reflect the very sample in which
  // a CPU cycle may be starting, so a colliding CPU cycle wins.
  assign ld_ready     = (state == S_IDLE) && !bus_active;
  assign unused_addr  = ^cyc_addr;

  // RAM port sharing: the loader owns it only while idle and unchallenged. A
  // starting CPU cycle steers the live address in so the registered read data
  // is ready by the ACCESS edge even with zero wait states.
  always_comb begin
    ram_addr  = ld_addr;
    ram_wdata = ld_data;
    ram_we    = ld_we & ld_ready;
    if (state == S_IDLE) begin
      if (bus_active) ram_addr = cpu_addr[AW-1:0];
    end else begin
      ram_addr  = cyc_addr[AW-1:0];
      ram_wdata = cpu_dout;
      ram_we    = (state == S_ACCESS) && (cyc_kind == K_WRITE) && !cyc_io;
    end
  end

  always_comb begin
    io_rdata = IO_UNMAPPED;
    for (int i = 0; i < N_PORTS; i++) begin
      if (cyc_addr[7:0] == 8'(i)) io_rdata = port_q[8*i +: 8];
    end
  end

  z80_bus_ram #(.MEM_DEPTH(MEM_DEPTH)) u_ram (
    .clk   (wb_clk_i),
    .we    (ram_we),
    .addr  (ram_addr),
    .wdata (ram_wdata),
    .rdata (ram_rdata)
  );

  always_ff @(posedge wb_clk_i or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      cyc_kind   <= K_READ;
      cyc_io     <= 1'b0;
      cyc_addr   <= '0;
      wait_cnt   <= 4'd0;
      vector     <= IRQ_VECTOR;
      irq_prev   <= 1'b0;
      irq_rearm  <= 1'b0;
      cpu_din    <= 8'h00;
      cpu_din_oe <= 1'b0;
      cpu_wait_n <= 1'b1;
      cpu_int_n  <= 1'b1;
      port_q     <= '0;
    end else begin
      irq_prev  <= irq_req;
      irq_rearm <= 1'b0;
      // An edge coinciding with the acknowledge is not lost: it re-asserts
      // the request one cycle after INTA clears it.
      if (inta_access) begin
        cpu_int_n <= 1'b1;
        irq_rearm <= irq_rise;
      end else if (irq_rise || irq_rearm) begin
        cpu_int_n <= 1'b0;
      end

      case (state)
        S_IDLE: begin
          if (bus_active) begin
            cyc_addr <= cpu_addr;
            cyc_kind <= decode_kind(cpu_iorq_n, cpu_wr_n, cpu_m1_n);
            cyc_io   <= cpu_mreq_n;
            if (WAIT_STATES > 0) begin
              state      <= S_WAIT;
              cpu_wait_n <= 1'b0;
              wait_cnt   <= WAIT_LOAD;
            end else begin
              state <= S_ACCESS;
            end
          end
        end
        S_WAIT: begin
          if (!bus_active) begin
            state      <= S_IDLE;
            cpu_wait_n <= 1'b1;
          end else if (wait_cnt == 4'd0) begin
            state      <= S_ACCESS;
            cpu_wait_n <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt - 4'd1;
          end
        end
        S_ACCESS: begin
          state <= S_HOLD;
          case (cyc_kind)
            K_READ: begin
              cpu_din    <= cyc_io ? io_rdata : ram_rdata;
              cpu_din_oe <= 1'b1;
            end
            K_WRITE: begin
              if (cyc_io) begin
                if (cyc_addr[7:0] == IO_VECTOR_ADDR) vector <= cpu_dout;
                for (int i = 0; i < N_PORTS; i++) begin
                  if (cyc_addr[7:0] == 8'(i)) port_q[8*i +: 8] <= cpu_dout;
                end
              end
            end
            K_INTA: begin
              cpu_din    <= vector;
              cpu_din_oe <= 1'b1;
            end
            default: ;
          endcase
        end
        S_HOLD: begin
          if (all_released) begin
            cpu_din_oe <= 1'b0;
            state      <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_z80_bus_target.sv
// tb/tb_z80_bus_target.sv - bench for z80_bus_target with zero and three wait states
module tb_z80_bus_target;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [15:0] cpu_addr = 16'h0;
  logic [7:0]  cpu_dout = 8'h0;
  logic        mreq_n = 1'b1, iorq_n = 1'b1, rd_n = 1'b1, wr_n = 1'b1, m1_n = 1'b1;
  logic        irq_req = 1'b0;
  logic        ld_we = 1'b0;
  logic [7:0]  ld_addr = 8'h0;
  logic [7:0]  ld_data = 8'h0;

  logic [7:0]  din_a, din_b;
  logic        oe_a, oe_b, wait_a, wait_b, int_a, int_b, ldr_a, ldr_b;
  logic [31:0] pq_a, pq_b;

  int total = 0;
  int bad = 0;
  int wl, fa, fb;

  always #5 clk = ~clk;

  z80_bus_target #(.WAIT_STATES(0)) dut_a (
    .wb_clk_i(clk), .rst_n(rst_n), .cpu_addr(cpu_addr), .cpu_dout(cpu_dout),
    .cpu_mreq_n(mreq_n), .cpu_iorq_n(iorq_n), .cpu_rd_n(rd_n), .cpu_wr_n(wr_n),
    .cpu_m1_n(m1_n), .cpu_din(din_a), .cpu_din_oe(oe_a), .cpu_wait_n(wait_a),
    .cpu_int_n(int_a), .irq_req(irq_req), .ld_we(ld_we), .ld_addr(ld_addr),
    .ld_data(ld_data), .ld_ready(ldr_a), .port_q(pq_a));

  z80_bus_target #(.WAIT_STATES(3)) dut_b (
    .wb_clk_i(clk), .rst_n(rst_n), .cpu_addr(cpu_addr), .cpu_dout(cpu_dout),
    .cpu_mreq_n(mreq_n), .cpu_iorq_n(iorq_n), .cpu_rd_n(rd_n), .cpu_wr_n(wr_n),
    .cpu_m1_n(m1_n), .cpu_din(din_b), .cpu_din_oe(oe_b), .cpu_wait_n(wait_b),
    .cpu_int_n(int_b), .irq_req(irq_req), .ld_we(ld_we), .ld_addr(ld_addr),
    .ld_data(ld_data), .ld_ready(ldr_b), .port_q(pq_b));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model (index 0: no waits, 1: three waits)
  logic [7:0]  m_mem  [2][256];
  logic [7:0]  m_port [2][4];
  logic [7:0]  m_vec  [2];
  logic [7:0]  m_din  [2];
  logic [15:0] m_addr [2];
  bit          m_busy [2], m_io [2], m_oe [2], m_wait [2], m_int [2], m_rearm [2];
  int          m_age  [2], m_kind [2];
  bit          m_prev;

  function automatic bit bus_cond();
    return ((!mreq_n || !iorq_n) && (!rd_n || !wr_n)) || (!iorq_n && !m1_n);
  endfunction

  task automatic model_step();
    bit cond, rise, all_hi;
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) begin
        m_busy[i] = 0; m_din[i] = 8'h00; m_oe[i] = 0; m_wait[i] = 1; m_int[i] = 1;
        m_vec[i] = 8'hFF; m_rearm[i] = 0; m_age[i] = 0;
        for (int p = 0; p < 4; p++) m_port[i][p] = 8'h00;
      end
      m_prev = 0;
      return;
    end
    cond   = bus_cond();
    rise   = irq_req && !m_prev;
    all_hi = mreq_n && iorq_n && rd_n && wr_n;
    for (int i = 0; i < 2; i++) begin
      int ws;
      bit inta_acc;
      ws = (i == 0) ? 0 : 3;
      inta_acc = 0;
      if (!m_busy[i]) begin
        if (cond) begin
          m_busy[i] = 1; m_age[i] = 0; m_addr[i] = cpu_addr; m_io[i] = mreq_n;
          m_kind[i] = (!iorq_n && !m1_n) ? 2 : (!wr_n ? 1 : 0);
          if (ws > 0) m_wait[i] = 0;
        end else if (ld_we) begin
          m_mem[i][ld_addr] = ld_data;
        end
      end else begin
        m_age[i]++;
        if (m_age[i] <= ws && !cond) begin
          m_busy[i] = 0; m_wait[i] = 1;
        end else if (m_age[i] == ws) begin
          m_wait[i] = 1;
        end else if (m_age[i] == ws + 1) begin
          if (m_kind[i] == 0) begin
            if (m_io[i]) m_din[i] = (m_addr[i][7:0] < 4) ? m_port[i][m_addr[i][1:0]] : 8'hFF;
            else         m_din[i] = m_mem[i][m_addr[i] % 256];
            m_oe[i] = 1;
          end else if (m_kind[i] == 1) begin
            if (!m_io[i])                   m_mem[i][m_addr[i] % 256] = cpu_dout;
            else if (m_addr[i][7:0] == 8'hFF) m_vec[i] = cpu_dout;
            else if (m_addr[i][7:0] < 4)    m_port[i][m_addr[i][1:0]] = cpu_dout;
          end else begin
            m_din[i] = m_vec[i]; m_oe[i] = 1; inta_acc = 1;
          end
        end else if (all_hi) begin
          m_oe[i] = 0; m_busy[i] = 0;
        end
      end
      if (inta_acc) begin
        m_int[i] = 1; m_rearm[i] = rise;
      end else if (rise || m_rearm[i]) begin
        m_int[i] = 0; m_rearm[i] = 0;
      end else begin
        m_rearm[i] = 0;
      end
    end
    m_prev = irq_req;
  endtask

  task automatic compare_all();
    for (int i = 0; i < 2; i++) begin
      logic [31:0] pq;
      pq = {m_port[i][3], m_port[i][2], m_port[i][1], m_port[i][0]};
      chk($sformatf("din_%0d", i),   i ? din_b  : din_a,  m_din[i]);
      chk($sformatf("oe_%0d", i),    i ? oe_b   : oe_a,   m_oe[i]);
      chk($sformatf("wait_%0d", i),  i ? wait_b : wait_a, m_wait[i]);
      chk($sformatf("int_%0d", i),   i ? int_b  : int_a,  m_int[i]);
      chk($sformatf("ldrdy_%0d", i), i ? ldr_b  : ldr_a,  !m_busy[i] && !bus_cond());
      chk($sformatf("portq_%0d", i), i ? pq_b   : pq_a,   pq);
    end
  endtask

  initial forever begin
    @(posedge clk or negedge rst_n);
    model_step();
  end

  initial forever begin
    @(posedge clk);
    #2;
    compare_all();
  end

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1);
  end

  // ---------------- directed stimulus
  task automatic ld_write(input logic [7:0] a, input logic [7:0] d);
    @(negedge clk);
    ld_we = 1'b1; ld_addr = a; ld_data = d;
    @(negedge clk);
    ld_we = 1'b0;
  endtask

  // kind: 0 read, 1 write, 2 INTA. Counts dut_b wait-low negedges and the
  // first negedge index at which each DUT drives the bus.
  task automatic cpu_cycle(input int kind, input bit io, input logic [15:0] a,
                           input logic [7:0] d, input int hold, input bit with_ld,
                           output int wl_b, output int first_a, output int first_b);
    @(negedge clk);
    cpu_addr = a; cpu_dout = d;
    if (kind == 2) begin
      iorq_n = 1'b0; m1_n = 1'b0;
    end else begin
      if (io) iorq_n = 1'b0; else mreq_n = 1'b0;
      if (kind == 1) wr_n = 1'b0; else rd_n = 1'b0;
    end
    if (with_ld) begin
      ld_we = 1'b1; ld_addr = 8'h05; ld_data = 8'h99;
    end
    wl_b = 0; first_a = 0; first_b = 0;
    for (int i = 1; i <= hold; i++) begin
      @(negedge clk);
      if (i == 1 && with_ld) begin
        chk("ldrdy_busy_a", ldr_a, 0);
        chk("ldrdy_busy_b", ldr_b, 0);
      end
      if (!wait_b) wl_b++;
      if (oe_a && first_a == 0) first_a = i;
      if (oe_b && first_b == 0) first_b = i;
    end
    mreq_n = 1'b1; iorq_n = 1'b1; rd_n = 1'b1; wr_n = 1'b1; m1_n = 1'b1; ld_we = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    #2 rst_n = 1'b0;
    #1;
    chk("rst_din",   din_a,  8'h00);
    chk("rst_oe",    oe_a,   0);
    chk("rst_wait",  wait_a, 1);
    chk("rst_int",   int_a,  1);
    chk("rst_ldrdy", ldr_a,  1);
    chk("rst_portq", pq_a,   32'h0);
    chk("rst_wait_b", wait_b, 1);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    ld_write(8'h00, 8'h3E);
    ld_write(8'h01, 8'h55);
    ld_write(8'h05, 8'h5A);
    ld_write(8'h10, 8'h11);
    ld_write(8'h20, 8'h22);

    // memory read, zero and three wait states side by side
    cpu_cycle(0, 0, 16'h0001, 8'h00, 6, 0, wl, fa, fb);
    chk("rd1_din_a", din_a, 8'h55);
    chk("rd1_din_b", din_b, 8'h55);
    chk("rd1_lat_a", fa, 2);
    chk("rd1_lat_b", fb, 5);
    chk("rd1_waitcnt_b", wl, 3);
    chk("rd1_oe_drop_b", oe_b, 0);

    // I/O ports and vector register
    cpu_cycle(1, 1, 16'h0002, 8'hA5, 6, 0, wl, fa, fb);
    chk("io_wr_a", pq_a[23:16], 8'hA5);
    chk("io_wr_b", pq_b[23:16], 8'hA5);
    cpu_cycle(0, 1, 16'h0009, 8'h00, 6, 0, wl, fa, fb);
    chk("io_unmapped_a", din_a, 8'hFF);
    chk("io_unmapped_b", din_b, 8'hFF);
    cpu_cycle(0, 1, 16'h0002, 8'h00, 6, 0, wl, fa, fb);
    chk("io_rd_a", din_a, 8'hA5);
    cpu_cycle(1, 1, 16'h00FF, 8'h40, 6, 0, wl, fa, fb);

    // interrupt request and acknowledge
    @(negedge clk); irq_req = 1'b1;
    @(negedge clk);
    chk("irq_a", int_a, 0);
    chk("irq_b", int_b, 0);
    cpu_cycle(2, 1, 16'h0000, 8'h00, 6, 0, wl, fa, fb);
    chk("inta_vec_a", din_a, 8'h40);
    chk("inta_vec_b", din_b, 8'h40);
    chk("inta_clr_a", int_a, 1);
    chk("inta_clr_b", int_b, 1);

    // edge landing on dut_a's INTA access edge re-arms; dut_b merges it
    @(negedge clk); irq_req = 1'b0;
    @(negedge clk); irq_req = 1'b1;
    @(negedge clk); irq_req = 1'b0;
    @(negedge clk); iorq_n = 1'b0; m1_n = 1'b0;
    @(negedge clk); irq_req = 1'b1;
    @(negedge clk);
    chk("rearm_clr_a", int_a, 1);
    @(negedge clk);
    chk("rearm_set_a", int_a, 0);
    chk("merge_b", int_b, 0);
    repeat (3) @(negedge clk);
    chk("merge_clr_b", int_b, 1);
    iorq_n = 1'b1; m1_n = 1'b1; irq_req = 1'b0;
    repeat (2) @(negedge clk);

    // address mirroring and loader collision
    cpu_cycle(0, 0, 16'h0105, 8'h00, 6, 1, wl, fa, fb);
    chk("mirror_a", din_a, 8'h5A);
    chk("mirror_b", din_b, 8'h5A);
    cpu_cycle(0, 0, 16'h0005, 8'h00, 6, 0, wl, fa, fb);
    chk("ld_drop_a", din_a, 8'h5A);
    chk("ld_drop_b", din_b, 8'h5A);

    // strobes released mid-WAIT abort dut_b's write; dut_a completes it
    cpu_cycle(1, 0, 16'h0010, 8'h77, 2, 0, wl, fa, fb);
    chk("abort_wait_b", wait_b, 1);
    cpu_cycle(0, 0, 16'h0010, 8'h00, 6, 0, wl, fa, fb);
    chk("abort_wr_a", din_a, 8'h77);
    chk("abort_wr_b", din_b, 8'h11);

    // reset mid-WAIT
    @(negedge clk);
    cpu_addr = 16'h0020; cpu_dout = 8'h88; mreq_n = 1'b0; wr_n = 1'b0;
    @(negedge clk);
    chk("midwait_b", wait_b, 0);
    #1 rst_n = 1'b0;
    #1;
    chk("rstmid_wait_b", wait_b, 1);
    chk("rstmid_oe_b", oe_b, 0);
    chk("rstmid_int_a", int_a, 1);
    @(negedge clk);
    mreq_n = 1'b1; wr_n = 1'b1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    cpu_cycle(0, 0, 16'h0020, 8'h00, 6, 0, wl, fa, fb);
    chk("rstmid_ram_a", din_a, 8'h22);
    chk("rstmid_ram_b", din_b, 8'h22);

    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
